modfa_sched: RTL and testbench

Round-robin scheduler that shares one `modfa` modular adder/subtractor among `NREQ` requesters, such as the point-add and point-double sequencers in the ECC core. It arbitrates, captures the winner's operands, and pulses `modfa.en` for one cycle. It then waits for `modfa.vld` (with a watchdog) and returns the result to the owning requester with a one-cycle done pulse.

---
 rtl/modfa_sched_pkg.sv | 22 ++
 rtl/modfa_sched_rr_pick.sv | 40 ++++
 rtl/modfa_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_modfa_sched.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modfa_sched_pkg.sv
// ---------------------------------------------------------------------------
// modfa_sched_pkg
//
// Shared definitions for the modfa round-robin scheduler:
//   state_t    - scheduler FSM states (IDLE / ISSUE / WAIT, encoded 0/1/2)
//   *_DEF      - default parameter values used by the top module
// ---------------------------------------------------------------------------
package modfa_sched_pkg;

   // Scheduler states: arbitrate, fire the adder, then wait for its result
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam int WIDTH_DEF = 256;
   localparam int NREQ_DEF  = 4;
   localparam int TMO_DEF   = 64;
   localparam int TMOW_DEF  = 7;

endpackage

// File: rtl/modfa_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Purely combinational rotate-priority encoder. The search starts at index
// rr and wraps, so the requester at rr has the highest priority, rr+1 the
// next, and so on.
//
// Ports:
//   req  in   NREQ   request vector
//   rr   in   IDXW   index where the priority search starts
//   any  out  1      at least one request is set
//   win  out  IDXW   index of the winning requester (rr when none is set)
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDXW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] rr,
   output logic            any,
   output logic [IDXW-1:0] win
);

   // Walk the offsets from the lowest priority (rr+NREQ-1) down to the
   // highest (rr+0). Each set request overwrites the previous candidate, so
   // the one closest to rr is left standing at the end of the loop.
   always_comb begin
      logic [IDXW-1:0] idx;
      idx = '0;
      any = |req;
      win = rr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IDXW'((int'(rr) + k) % NREQ);
         if (req[idx]) begin
            win = idx;
         end
      end
   end

endmodule

// File: rtl/modfa_sched.sv
// ---------------------------------------------------------------------------
// modfa_sched
//
// Shares a single modfa modular adder/subtractor between NREQ requesters.
// A round-robin arbiter picks one requester, its operands are captured and
// the adder is fired with a one-cycle enable. The scheduler then waits for
// the adder's valid (bounded by a watchdog of TMO cycles) and hands the
// result back to the owning requester with a one-cycle done pulse.
//
// Ports:
//   clk       in   1            clock, rising edge
//   rst       in   1            synchronous active-high reset
//   req       in   NREQ         per-requester request level
//   req_op1   in   NREQ*WIDTH   packed op1, slice i = [i*WIDTH +: WIDTH]
//   req_op2   in   NREQ*WIDTH   packed op2
//   req_sub   in   NREQ         1 = subtract, 0 = add
//   mod       in   WIDTH        shared modulus (quasi-static)
//   gnt       out  NREQ         one-hot pulse: operands captured
//   rsp_done  out  NREQ         one-hot pulse: result ready for the owner
//   rsp_sum   out  WIDTH        result, valid with rsp_done
//   rsp_err   out  1            watchdog expired, valid with rsp_done
//   busy      out  1            scheduler is not idle
//   fa_op1    out  WIDTH        adder op1
//   fa_op2    out  WIDTH        adder op2
//   fa_mod    out  WIDTH        adder modulus
//   fa_cin    out  1            adder subtract select
//   fa_en     out  1            adder start pulse
//   fa_sum    in   WIDTH        adder result
//   fa_vld    in   1            adder result valid
// ---------------------------------------------------------------------------
module modfa_sched
   import modfa_sched_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREQ  = NREQ_DEF,
   parameter int TMO   = TMO_DEF,
   parameter int TMOW  = TMOW_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_op1,
   input  logic [NREQ*WIDTH-1:0] req_op2,
   input  logic [NREQ-1:0]       req_sub,
   input  logic [WIDTH-1:0]      mod,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       rsp_done,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_err,
   output logic                  busy,
   output logic [WIDTH-1:0]      fa_op1,
   output logic [WIDTH-1:0]      fa_op2,
   output logic [WIDTH-1:0]      fa_mod,
   output logic                  fa_cin,
   output logic                  fa_en,
   input  logic [WIDTH-1:0]      fa_sum,
   input  logic                  fa_vld
);

   localparam int              IDXW     = $clog2(NREQ);
   localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TMO - 1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);

   state_t            state;
   state_t            state_n;
   logic              pick_any;
   logic [IDXW-1:0]   pick_win;
   logic [IDXW-1:0]   owner;
   logic [IDXW-1:0]   rr;
   logic [TMOW-1:0]   tcnt;
   logic [WIDTH-1:0]  sel_op1;
   logic [WIDTH-1:0]  sel_op2;
   logic              sel_sub;
   logic              capture;
   logic              done_ok;
   logic              done_tmo;

   // Round-robin winner among the current requests, searching from rr
   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_pick (
      .req (req),
      .rr  (rr),
      .any (pick_any),
      .win (pick_win)
   );

   // Operand mux: route the winner's slice of the packed operand buses to
   // the capture registers. This is the only combinational path from req.
   always_comb begin
      sel_op1 = '0;
      sel_op2 = '0;
      sel_sub = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_win == IDXW'(i)) begin
            sel_op1 = req_op1[i*WIDTH +: WIDTH];
            sel_op2 = req_op2[i*WIDTH +: WIDTH];
            sel_sub = req_sub[i];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic and one-cycle strobes for the datapath. A valid from
   // the adder takes priority over the watchdog when both land together, and
   // the adder's valid is only looked at while waiting.
   always_comb begin
      state_n  = state;
      capture  = 1'b0;
      done_ok  = 1'b0;
      done_tmo = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               capture = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            state_n = WAIT;
         end
         WAIT: begin
            if (fa_vld) begin
               done_ok = 1'b1;
               state_n = IDLE;
            end else if (tcnt == TMO_LAST) begin
               done_tmo = 1'b1;
               state_n  = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Arbitration bookkeeping: remember who owns the adder and move the
   // round-robin pointer just past the winner so it has lowest priority next.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner <= '0;
         rr    <= '0;
      end else if (capture) begin
         owner <= pick_win;
         rr    <= (pick_win == IDX_LAST) ? '0 : pick_win + 1'b1;
      end
   end

   // Adder interface. Operands and modulus are loaded on the arbitration
   // edge so they are already stable in the cycle the enable pulse and the
   // grant are visible; they then hold until the next capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         fa_op1 <= '0;
         fa_op2 <= '0;
         fa_mod <= '0;
         fa_cin <= 1'b0;
         fa_en  <= 1'b0;
         gnt    <= '0;
      end else begin
         fa_en <= capture;
         gnt   <= capture ? (NREQ'(1) << pick_win) : '0;
         if (capture) begin
            fa_op1 <= sel_op1;
            fa_op2 <= sel_op2;
            fa_mod <= mod;
            fa_cin <= sel_sub;
         end
      end
   end

   // Watchdog: cleared while the enable pulse is out, then counts every
   // waiting cycle. The next-state logic gives up once it reaches TMO-1,
   // which puts the error response TMO+1 cycles after the enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt <= '0;
      end else if (state == ISSUE) begin
         tcnt <= '0;
      end else if (state == WAIT) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // Response back to the owner. The sum and error flag keep their last
   // value between responses; the done pulse lasts a single cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_done <= '0;
         rsp_sum  <= '0;
         rsp_err  <= 1'b0;
      end else begin
         rsp_done <= '0;
         if (done_ok) begin
            rsp_sum  <= fa_sum;
            rsp_err  <= 1'b0;
            rsp_done <= NREQ'(1) << owner;
         end else if (done_tmo) begin
            rsp_sum  <= '0;
            rsp_err  <= 1'b1;
            rsp_done <= NREQ'(1) << owner;
         end
      end
   end

   // Busy mirrors the state we are about to enter so it stays registered
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
      end else begin
         busy <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_modfa_sched.sv
// ---------------------------------------------------------------------------
// tb_modfa_sched
//
// Bench for modfa_sched: directed scenarios with hand-computed expectations,
// followed by randomized requesters and a randomized modfa stub. A timeline
// model of the scheduler predicts every output and is compared each cycle.
// ---------------------------------------------------------------------------
module tb_modfa_sched;

   localparam int WIDTH = 32;
   localparam int NREQ  = 4;
   localparam int TMO   = 16;
   localparam int TMOW  = 5;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_op1;
   logic [NREQ*WIDTH-1:0] req_op2;
   logic [NREQ-1:0]       req_sub;
   logic [WIDTH-1:0]      mod;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       rsp_done;
   logic [WIDTH-1:0]      rsp_sum;
   logic                  rsp_err;
   logic                  busy;
   logic [WIDTH-1:0]      fa_op1;
   logic [WIDTH-1:0]      fa_op2;
   logic [WIDTH-1:0]      fa_mod;
   logic                  fa_cin;
   logic                  fa_en;
   logic [WIDTH-1:0]      fa_sum;
   logic                  fa_vld;

   int errors = 0;
   int checks = 0;

   // Stub control: fixed latency (<=0 means never answer) or random mode
   int stub_delay = -1;
   bit stub_rand  = 1'b0;

   modfa_sched #(
      .WIDTH (WIDTH),
      .NREQ  (NREQ),
      .TMO   (TMO),
      .TMOW  (TMOW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_op1  (req_op1),
      .req_op2  (req_op2),
      .req_sub  (req_sub),
      .mod      (mod),
      .gnt      (gnt),
      .rsp_done (rsp_done),
      .rsp_sum  (rsp_sum),
      .rsp_err  (rsp_err),
      .busy     (busy),
      .fa_op1   (fa_op1),
      .fa_op2   (fa_op2),
      .fa_mod   (fa_mod),
      .fa_cin   (fa_cin),
      .fa_en    (fa_en),
      .fa_sum   (fa_sum),
      .fa_vld   (fa_vld)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int i, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic s);
      req_op1[i*WIDTH +: WIDTH] = a;
      req_op2[i*WIDTH +: WIDTH] = b;
      req_sub[i]                = s;
      req[i]                    = 1'b1;
   endtask

   task automatic waitGnt(input string name, output logic [NREQ-1:0] g);
      g = '0;
      for (int k = 0; k < 50 && g == '0; k++) begin
         tick();
         g = gnt;
      end
      checks++;
      if (g == '0) begin
         errors++;
         $display("[TB] FAIL %s: gnt stayed 0 for 50 cycles, expected a grant", name);
      end
   endtask

   task automatic waitDone(input string name, output int n);
      bit seen;
      seen = 1'b0;
      n    = 0;
      for (int k = 0; k < TMO + 30 && !seen; k++) begin
         tick();
         n++;
         if (rsp_done != '0) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL %s: rsp_done stayed 0 for %0d cycles, expected a response", name, n);
      end
   endtask

   // modfa stub: answers a fixed or random number of cycles after fa_en with
   // the true modular result of the operands it was handed. In random mode it
   // also raises stray valids while idle, which the scheduler must ignore.
   initial begin
      int      cnt;
      int      dly;
      bit      armed;
      longint  a, b, p, r;
      fa_vld = 1'b0;
      fa_sum = '0;
      armed  = 1'b0;
      cnt    = 0;
      dly    = 0;
      r      = 0;
      forever begin
         tick();
         fa_vld = 1'b0;
         if (fa_en === 1'b1) begin
            armed = 1'b1;
            cnt   = 0;
            a = longint'(fa_op1);
            b = longint'(fa_op2);
            p = longint'(fa_mod);
            if (p == 0) p = 1;
            if (fa_cin) r = (a - b) % p;
            else        r = (a + b) % p;
            if (r < 0) r = r + p;
            if (stub_rand) begin
               case ($urandom_range(0, 9))
                  0:       dly = TMO;
                  1:       dly = -1;
                  2:       dly = TMO + 3;
                  default: dly = int'($urandom_range(1, 6));
               endcase
            end else begin
               dly = stub_delay;
            end
         end else if (armed) begin
            cnt++;
            if (dly > 0 && cnt == dly) begin
               fa_vld = 1'b1;
               fa_sum = WIDTH'(r);
               armed  = 1'b0;
            end
         end else if (stub_rand && $urandom_range(0, 7) == 0) begin
            fa_vld = 1'b1;
            fa_sum = $urandom;
         end
      end
   end

   // Timeline model. Each falling edge it first compares the DUT outputs with
   // what it predicted, then looks at the inputs about to be sampled and
   // predicts the outputs after the next rising edge: an arbitration cycle
   // grants at the next cycle (the issue cycle), the answer is the first
   // valid seen after the issue cycle, or an error once TMO cycles have
   // passed since the issue cycle.
   initial begin
      bit               m_valid;
      bit               m_free;
      int               m_rr;
      int               m_owner;
      longint           m_issue;
      longint           cyc;
      int               w;
      logic [NREQ-1:0]  e_gnt;
      logic [NREQ-1:0]  e_done;
      logic [WIDTH-1:0] e_sum;
      logic [WIDTH-1:0] e_op1;
      logic [WIDTH-1:0] e_op2;
      logic [WIDTH-1:0] e_mod;
      logic             e_err;
      logic             e_busy;
      logic             e_en;
      logic             e_cin;
      m_valid = 1'b0;
      m_free  = 1'b1;
      m_rr    = 0;
      m_owner = 0;
      m_issue = 0;
      cyc     = 0;
      forever begin
         @(negedge clk);
         if (m_valid) begin
            checkOutput("model_gnt",      gnt,      e_gnt);
            checkOutput("model_fa_en",    fa_en,    e_en);
            checkOutput("model_rsp_done", rsp_done, e_done);
            checkOutput("model_busy",     busy,     e_busy);
            checkOutput("model_fa_op1",   fa_op1,   e_op1);
            checkOutput("model_fa_op2",   fa_op2,   e_op2);
            checkOutput("model_fa_mod",   fa_mod,   e_mod);
            checkOutput("model_fa_cin",   fa_cin,   e_cin);
            if (e_done != '0) begin
               checkOutput("model_rsp_sum", rsp_sum, e_sum);
               checkOutput("model_rsp_err", rsp_err, e_err);
            end
         end
         if (rst === 1'b1) begin
            m_valid = 1'b1;
            m_free  = 1'b1;
            m_rr    = 0;
            m_owner = 0;
            e_gnt   = '0;
            e_done  = '0;
            e_sum   = '0;
            e_err   = 1'b0;
            e_busy  = 1'b0;
            e_en    = 1'b0;
            e_op1   = '0;
            e_op2   = '0;
            e_mod   = '0;
            e_cin   = 1'b0;
         end else if (m_valid) begin
            e_gnt  = '0;
            e_en   = 1'b0;
            e_done = '0;
            if (m_free) begin
               if (req != '0) begin
                  w = -1;
                  for (int k = 0; k < NREQ; k++) begin
                     if (w < 0 && req[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
                  end
                  e_gnt   = '0;
                  e_gnt[w] = 1'b1;
                  e_en    = 1'b1;
                  e_op1   = req_op1[w*WIDTH +: WIDTH];
                  e_op2   = req_op2[w*WIDTH +: WIDTH];
                  e_cin   = req_sub[w];
                  e_mod   = mod;
                  m_owner = w;
                  m_rr    = (w + 1) % NREQ;
                  m_free  = 1'b0;
                  m_issue = cyc + 1;
               end
            end else if (cyc > m_issue) begin
               if (fa_vld === 1'b1) begin
                  e_done          = '0;
                  e_done[m_owner] = 1'b1;
                  e_sum           = fa_sum;
                  e_err           = 1'b0;
                  m_free          = 1'b1;
               end else if (cyc - m_issue == TMO) begin
                  e_done          = '0;
                  e_done[m_owner] = 1'b1;
                  e_sum           = '0;
                  e_err           = 1'b1;
                  m_free          = 1'b1;
               end
            end
            e_busy = !m_free;
         end
         cyc++;
      end
   end

   // Directed scenarios, then randomized traffic
   initial begin
      logic [NREQ-1:0] g;
      int              n;
      rst     = 1'b1;
      req     = '0;
      req_sub = '0;
      req_op1 = '0;
      req_op2 = '0;
      mod     = '0;
      tick();
      tick();
      rst = 1'b0;

      $display("[TB] reset values");
      checkOutput("rst_gnt",      gnt,      0);
      checkOutput("rst_rsp_done", rsp_done, 0);
      checkOutput("rst_rsp_sum",  rsp_sum,  0);
      checkOutput("rst_rsp_err",  rsp_err,  0);
      checkOutput("rst_busy",     busy,     0);
      checkOutput("rst_fa_en",    fa_en,    0);
      checkOutput("rst_fa_op1",   fa_op1,   0);
      checkOutput("rst_fa_mod",   fa_mod,   0);
      checkOutput("rst_fa_cin",   fa_cin,   0);

      $display("[TB] single add 5+9 mod 11");
      mod        = 11;
      stub_delay = 6;
      applyStimulus(0, 5, 9, 1'b0);
      tick();
      checkOutput("add_gnt",    gnt,    4'b0001);
      checkOutput("add_fa_en",  fa_en,  1);
      checkOutput("add_fa_cin", fa_cin, 0);
      checkOutput("add_fa_op1", fa_op1, 5);
      checkOutput("add_busy",   busy,   1);
      req = '0;
      waitDone("add_wait", n);
      checkOutput("add_latency",  n,        7);
      checkOutput("add_rsp_done", rsp_done, 4'b0001);
      checkOutput("add_rsp_sum",  rsp_sum,  3);
      checkOutput("add_rsp_err",  rsp_err,  0);

      $display("[TB] round robin with all requesters");
      rst = 1'b1;
      tick();
      rst        = 1'b0;
      stub_delay = 2;
      for (int i = 0; i < NREQ; i++) applyStimulus(i, WIDTH'(i + 1), 2, 1'b0);
      for (int k = 0; k < 5; k++) begin
         waitGnt("rr_wait", g);
         checkOutput("rr_order", g, 1 << (k % 4));
      end
      req = '0;
      waitDone("rr_last", n);
      checkOutput("rr_last_done", rsp_done, 4'b0001);

      $display("[TB] subtract 3-7 mod 11");
      stub_delay = 4;
      applyStimulus(2, 3, 7, 1'b1);
      tick();
      checkOutput("sub_gnt",    gnt,    4'b0100);
      checkOutput("sub_fa_cin", fa_cin, 1);
      checkOutput("sub_fa_op1", fa_op1, 3);
      checkOutput("sub_fa_op2", fa_op2, 7);
      checkOutput("sub_fa_mod", fa_mod, 11);
      req = '0;
      waitDone("sub_wait", n);
      checkOutput("sub_rsp_done", rsp_done, 4'b0100);
      checkOutput("sub_rsp_sum",  rsp_sum,  7);
      checkOutput("sub_rsp_err",  rsp_err,  0);

      $display("[TB] timeout");
      stub_delay = -1;
      applyStimulus(3, 1, 2, 1'b0);
      tick();
      checkOutput("tmo_gnt", gnt, 4'b1000);
      req = '0;
      waitDone("tmo_wait", n);
      checkOutput("tmo_latency",  n,        TMO + 1);
      checkOutput("tmo_rsp_done", rsp_done, 4'b1000);
      checkOutput("tmo_rsp_err",  rsp_err,  1);
      checkOutput("tmo_rsp_sum",  rsp_sum,  0);
      stub_delay = 3;
      applyStimulus(0, 4, 5, 1'b0);
      tick();
      checkOutput("after_tmo_gnt", gnt, 4'b0001);
      req = '0;
      waitDone("after_tmo_wait", n);
      checkOutput("after_tmo_latency", n,       4);
      checkOutput("after_tmo_sum",     rsp_sum, 9);
      checkOutput("after_tmo_err",     rsp_err, 0);

      $display("[TB] valid on the last watchdog cycle");
      stub_delay = TMO;
      applyStimulus(1, 6, 8, 1'b0);
      tick();
      checkOutput("edge_gnt", gnt, 4'b0010);
      req = '0;
      waitDone("edge_wait", n);
      checkOutput("edge_latency",  n,        TMO + 1);
      checkOutput("edge_rsp_done", rsp_done, 4'b0010);
      checkOutput("edge_rsp_err",  rsp_err,  0);
      checkOutput("edge_rsp_sum",  rsp_sum,  3);

      $display("[TB] reset while waiting");
      stub_delay = 4;
      applyStimulus(2, 1, 1, 1'b0);
      tick();
      checkOutput("mid_gnt", gnt, 4'b0100);
      req = '0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_rst_gnt",      gnt,      0);
      checkOutput("mid_rst_rsp_done", rsp_done, 0);
      checkOutput("mid_rst_rsp_sum",  rsp_sum,  0);
      checkOutput("mid_rst_rsp_err",  rsp_err,  0);
      checkOutput("mid_rst_busy",     busy,     0);
      checkOutput("mid_rst_fa_en",    fa_en,    0);
      checkOutput("mid_rst_fa_op1",   fa_op1,   0);
      checkOutput("mid_rst_fa_mod",   fa_mod,   0);
      tick();
      checkOutput("mid_late_vld_done", rsp_done, 0);
      checkOutput("mid_late_vld_busy", busy,     0);
      stub_delay = 2;
      for (int i = 0; i < NREQ; i++) applyStimulus(i, 1, 1, 1'b0);
      tick();
      checkOutput("mid_first_gnt", gnt, 4'b0001);
      req = '0;
      waitDone("mid_final", n);

      $display("[TB] randomized traffic");
      mod       = $urandom_range(2, 32'h7fff_ffff);
      stub_rand = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 599) == 0) rst = 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
               if ($urandom_range(0, 2) == 0)
                  applyStimulus(i, $urandom % mod, $urandom % mod, 1'($urandom_range(0, 1)));
               else
                  req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 5) == 0) begin
               applyStimulus(i, $urandom % mod, $urandom % mod, 1'($urandom_range(0, 1)));
            end
         end
         tick();
      end
      rst       = 1'b0;
      req       = '0;
      stub_rand = 1'b0;
      repeat (TMO + 10) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
